// File: rtl/operand_forward_unit.sv
// operand_forward_unit
// Operand forwarding and load-use hazard unit for the instruction in ID that is
// about to issue into EX. A shadow pipeline of FWD_DEPTH entries tracks the
// register writes in flight (entry 0 = EX, entry k = k stages after EX). For each
// source operand, the unit picks the youngest matching in-flight result, or the
// register-file data when nothing matches. It stalls issue while a needed load
// result does not exist yet.
//
// Ports:
//   clk, rst      rising-edge clock; asynchronous active-high reset
//   id_valid      ID holds a valid instruction requesting issue
//   id_rs         source register addresses, src i at [i*RA_W +: RA_W]
//   id_rs_used    per-source read enable
//   id_rdata      register-file read data per source
//   id_rd         destination register of the ID instruction
//   id_reg_write  ID instruction writes rd
//   id_is_load    ID instruction is a load
//   stage_data    result of the instruction in entry k at [k*XLEN +: XLEN]
//   flush         kill the ID instruction (entry 0 receives a bubble)
//   op_data       resolved operand per source (combinational)
//   fwd_sel       per source: 0 = register file, k+1 = entry k (combinational)
//   stall         hold ID and PC this cycle (combinational)
//   stall_cnt     saturating count of stalled cycles (registered)
module operand_forward_unit #(
   parameter int XLEN      = 32,
   parameter int RA_W      = 5,
   parameter int NUM_SRC   = 2,
   parameter int FWD_DEPTH = 3,
   parameter int LOAD_LAT  = 1,
   parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      id_valid,
   input  logic [NUM_SRC*RA_W-1:0]   id_rs,
   input  logic [NUM_SRC-1:0]        id_rs_used,
   input  logic [NUM_SRC*XLEN-1:0]   id_rdata,
   input  logic [RA_W-1:0]           id_rd,
   input  logic                      id_reg_write,
   input  logic                      id_is_load,
   input  logic [FWD_DEPTH*XLEN-1:0] stage_data,
   input  logic                      flush,
   output logic [NUM_SRC*XLEN-1:0]   op_data,
   output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
   output logic                      stall,
   output logic [31:0]               stall_cnt
);

   // Shadow pipeline entries
   logic [FWD_DEPTH-1:0] ent_valid_r;
   logic [FWD_DEPTH-1:0] ent_wr_r;
   logic [FWD_DEPTH-1:0] ent_ld_r;
   logic [RA_W-1:0]      ent_rd_r [FWD_DEPTH];

   logic [NUM_SRC-1:0]   found_s;
   logic [NUM_SRC-1:0]   blocked_s;
   logic                 issue_s;

   // Per-source operand selection: youngest matching entry wins; a load that is
   // too young to have its data blocks the source, even if older entries match
   always_comb begin
      found_s   = '0;
      blocked_s = '0;
      fwd_sel   = '0;
      op_data   = id_rdata;
      for (int i = 0; i < NUM_SRC; i++) begin
         for (int k = 0; k < FWD_DEPTH; k++) begin
            if (!found_s[i] && ent_valid_r[k] && ent_wr_r[k] &&
                (ent_rd_r[k] == id_rs[i*RA_W +: RA_W]) &&
                (id_rs[i*RA_W +: RA_W] != {RA_W{1'b0}}) && id_rs_used[i]) begin
               found_s[i] = 1'b1;
               if (ent_ld_r[k] && (k < LOAD_LAT)) begin
                  blocked_s[i] = 1'b1;
               end else begin
                  fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
                  op_data[i*XLEN +: XLEN]   = stage_data[k*XLEN +: XLEN];
               end
            end else begin
               found_s[i] = found_s[i];
            end
         end
      end
   end

   assign stall   = id_valid && !flush && (|blocked_s);
   assign issue_s = id_valid && !stall && !flush;

   // Shadow pipeline advance: entry 0 takes the issuing instruction or a bubble,
   // older entries shift every cycle regardless of stall
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ent_valid_r <= '0;
         ent_wr_r    <= '0;
         ent_ld_r    <= '0;
         for (int k = 0; k < FWD_DEPTH; k++) begin
            ent_rd_r[k] <= {RA_W{1'b0}};
         end
      end else begin
         for (int k = 1; k < FWD_DEPTH; k++) begin
            ent_valid_r[k] <= ent_valid_r[k-1];
            ent_wr_r[k]    <= ent_wr_r[k-1];
            ent_ld_r[k]    <= ent_ld_r[k-1];
            ent_rd_r[k]    <= ent_rd_r[k-1];
         end
         if (issue_s) begin
            ent_valid_r[0] <= 1'b1;
            ent_rd_r[0]    <= id_rd;
            ent_wr_r[0]    <= id_reg_write && (id_rd != {RA_W{1'b0}});
            ent_ld_r[0]    <= id_is_load;
         end else begin
            ent_valid_r[0] <= 1'b0;
            ent_rd_r[0]    <= {RA_W{1'b0}};
            ent_wr_r[0]    <= 1'b0;
            ent_ld_r[0]    <= 1'b0;
         end
      end
   end

   // Saturating stall-cycle counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= 32'd0;
      end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end else begin
         stall_cnt <= stall_cnt;
      end
   end

endmodule

// File: tb/tb_operand_forward_unit.sv
// Testbench for operand_forward_unit: directed scenarios followed by random
// traffic, all checked against a reference model that keeps a queue of the
// instructions that issued (youngest first) and applies the forwarding rules.
module tb_operand_forward_unit;

   localparam int XLEN = 32;
   localparam int RA_W = 5;
   localparam int NS   = 2;
   localparam int FD   = 3;
   localparam int LL   = 1;
   localparam int SW   = $clog2(FD + 1);

   logic               clk = 1'b0;
   logic               rst;
   logic               id_valid;
   logic [NS*RA_W-1:0] id_rs;
   logic [NS-1:0]      id_rs_used;
   logic [NS*XLEN-1:0] id_rdata;
   logic [RA_W-1:0]    id_rd;
   logic               id_reg_write;
   logic               id_is_load;
   logic [FD*XLEN-1:0] stage_data;
   logic               flush;
   logic [NS*XLEN-1:0] op_data;
   logic [NS*SW-1:0]   fwd_sel;
   logic               stall;
   logic [31:0]        stall_cnt;

   operand_forward_unit #(.XLEN(XLEN), .RA_W(RA_W), .NUM_SRC(NS),
                          .FWD_DEPTH(FD), .LOAD_LAT(LL)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs),
      .id_rs_used(id_rs_used), .id_rdata(id_rdata), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_is_load(id_is_load),
      .stage_data(stage_data), .flush(flush), .op_data(op_data),
      .fwd_sel(fwd_sel), .stall(stall), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic            v;
      logic [RA_W-1:0] rd;
      logic            rw;
      logic            ld;
   } rec_t;

   rec_t        hist[$];
   logic        exp_stall;
   logic [31:0] exp_cnt;
   int          errors = 0;
   int          checks = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      for (int k = 0; k < FD; k++) hist.push_back(rec_t'(0));
      exp_cnt   = 32'd0;
      exp_stall = 1'b0;
   endtask

   task automatic set_in(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                         input logic [1:0] used, input logic [4:0] rd,
                         input logic rw, input logic ld, input logic fl);
      id_valid     = v;
      id_rs        = {rs1, rs0};
      id_rs_used   = used;
      id_rd        = rd;
      id_reg_write = rw;
      id_is_load   = ld;
      flush        = fl;
      id_rdata     = {$urandom(), $urandom()};
      stage_data   = {$urandom(), $urandom(), $urandom()};
   endtask

   // Let inputs settle, evaluate the model and compare all outputs
   task automatic settle_check();
      logic [RA_W-1:0] rs;
      logic [SW-1:0]   sel;
      logic [XLEN-1:0] data;
      logic            blk;
      logic            done;
      #2;
      exp_stall = 1'b0;
      for (int i = 0; i < NS; i++) begin
         rs   = id_rs[i*RA_W +: RA_W];
         sel  = '0;
         data = id_rdata[i*XLEN +: XLEN];
         blk  = 1'b0;
         done = 1'b0;
         for (int k = 0; k < hist.size(); k++) begin
            if (!done && hist[k].v && hist[k].rw && hist[k].rd == rs &&
                rs != 5'd0 && id_rs_used[i]) begin
               done = 1'b1;
               if (hist[k].ld && k < LL) blk = 1'b1;
               else begin
                  sel  = SW'(k + 1);
                  data = stage_data[k*XLEN +: XLEN];
               end
            end
         end
         if (!blk) begin
            chk($sformatf("fwd_sel[%0d]", i), 64'(fwd_sel[i*SW +: SW]), 64'(sel));
            chk($sformatf("op_data[%0d]", i), 64'(op_data[i*XLEN +: XLEN]), 64'(data));
         end
         if (blk && id_valid && !flush) exp_stall = 1'b1;
      end
      chk("stall", 64'(stall), 64'(exp_stall));
      chk("stall_cnt", 64'(stall_cnt), 64'(exp_cnt));
   endtask

   // Clock edge: record what issued into EX and update the expected counter
   task automatic clock_edge();
      rec_t r;
      @(posedge clk);
      r.v  = id_valid && !exp_stall && !flush;
      r.rd = id_rd;
      r.rw = id_reg_write;
      r.ld = id_is_load;
      hist.push_front(r);
      if (hist.size() > FD) void'(hist.pop_back());
      if (exp_stall && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
      #1;
   endtask

   task automatic step();
      settle_check();
      clock_edge();
   endtask

   initial begin
      rst = 1'b1;
      set_in(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
      model_reset();
      #12;
      // Reset state, while held and after release
      settle_check();
      chk("reset op_data", 64'(op_data), 64'(id_rdata));
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      // Back-to-back ALU dependency
      set_in(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0, 1'b0); step();
      set_in(1'b1, 5'd5, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
      stage_data[0 +: XLEN] = 32'h1234;
      settle_check();
      chk("alu sel0", 64'(fwd_sel[0 +: SW]), 64'd1);
      chk("alu data0", 64'(op_data[0 +: XLEN]), 64'h1234);
      chk("alu stall", 64'(stall), 64'd0);
      clock_edge();

      // Youngest wins
      set_in(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b0, 1'b0); step();
      set_in(1'b1, 5'd0, 5'd0, 2'b00, 5'd1, 1'b1, 1'b0, 1'b0); step();
      set_in(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b0, 1'b0); step();
      set_in(1'b1, 5'd0, 5'd7, 2'b10, 5'd0, 1'b0, 1'b0, 1'b0);
      stage_data[0 +: XLEN]      = 32'hBBBB;
      stage_data[2*XLEN +: XLEN] = 32'hAAAA;
      settle_check();
      chk("young sel1", 64'(fwd_sel[SW +: SW]), 64'd1);
      chk("young data1", 64'(op_data[XLEN +: XLEN]), 64'hBBBB);
      clock_edge();
      set_in(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0); step(); step(); step();

      // Load-use with one stall cycle
      set_in(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b1, 1'b0); step();
      set_in(1'b1, 5'd3, 5'd6, 2'b11, 5'd6, 1'b1, 1'b0, 1'b0);
      settle_check();
      chk("lu stall", 64'(stall), 64'd1);
      clock_edge();
      settle_check();
      chk("lu cnt", 64'(stall_cnt), 64'd1);
      chk("lu stall off", 64'(stall), 64'd0);
      chk("lu sel0", 64'(fwd_sel[0 +: SW]), 64'd2);
      chk("lu data0", 64'(op_data[0 +: XLEN]), 64'(stage_data[XLEN +: XLEN]));
      chk("lu bubble sel1", 64'(fwd_sel[SW +: SW]), 64'd0);
      clock_edge();

      // x0 never forwarded, unused source not forwarded
      set_in(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b0, 1'b0); step();
      set_in(1'b1, 5'd0, 5'd0, 2'b01, 5'd4, 1'b1, 1'b0, 1'b0);
      settle_check();
      chk("x0 sel0", 64'(fwd_sel[0 +: SW]), 64'd0);
      clock_edge();
      set_in(1'b1, 5'd0, 5'd4, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
      settle_check();
      chk("unused sel1", 64'(fwd_sel[SW +: SW]), 64'd0);
      chk("unused data1", 64'(op_data[XLEN +: XLEN]), 64'(id_rdata[XLEN +: XLEN]));
      clock_edge();

      // Flushed load never enters EX
      set_in(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b1, 1'b1); step();
      set_in(1'b1, 5'd9, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
      settle_check();
      chk("flush stall", 64'(stall), 64'd0);
      chk("flush sel0", 64'(fwd_sel[0 +: SW]), 64'd0);
      clock_edge();

      // Asynchronous reset in the middle of a stall
      set_in(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b1, 1'b0); step();
      set_in(1'b1, 5'd3, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
      settle_check();
      chk("rst pre stall", 64'(stall), 64'd1);
      #1 rst = 1'b1;
      #1;
      model_reset();
      chk("rst stall", 64'(stall), 64'd0);
      chk("rst cnt", 64'(stall_cnt), 64'd0);
      chk("rst sel", 64'(fwd_sel), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      // Random traffic over a small register range to provoke hazards
      for (int n = 0; n < 400; n++) begin
         set_in(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 2'($urandom()), 5'($urandom_range(0, 7)),
                1'($urandom()), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 9) == 0));
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
